// File: rtl/dpram_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module   : dpram_rd_streamer
// Brief    : Sweeps a window of words out of RAM port B and presents them as a
//            valid/ready stream, hiding read latency behind a credit FIFO.
// Revision : 1.0
// ============================================================================
module dpram_rd_streamer #(
    parameter int DW      = 64,
    parameter int AW      = 8,
    parameter int DEPTH   = 256,
    parameter int N_DELAY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          enb,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] dob,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready
);

    localparam int FIFO_DEPTH = N_DELAY + 2;
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [PW-1:0] C_LAST_PTR  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   C_CREDIT    = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_FULL      = CW'(FIFO_DEPTH);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   iss_q, iss_d;
    logic [AW:0]   len_q, len_d;
    logic [CW-1:0] infl_q, infl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wp_q, rp_q;
    logic [N_DELAY-1:0] pv_q, pl_q;
    logic [DW-1:0] fd_q [FIFO_DEPTH];
    logic          fl_q [FIFO_DEPTH];

    logic w_issue, w_last_issue, w_push, w_pop, w_head_last;

    always_comb begin
        // Inflight reads already own a FIFO slot, so the FIFO can never overflow.
        w_issue      = (state_q == S_READ) &&
                       (({1'b0, infl_q} + {1'b0, cnt_q}) < C_CREDIT);
        w_last_issue = w_issue && ((iss_q + (AW + 1)'(1)) == len_q);
        w_push       = pv_q[N_DELAY-1];
        w_pop        = (cnt_q != '0) && m_ready;
        w_head_last  = fl_q[rp_q];

        state_d = state_q;
        addr_d  = addr_q;
        iss_d   = iss_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_DONE : S_READ;
                    addr_d  = base_addr;
                    iss_d   = '0;
                    len_d   = len;
                end
            end
            S_READ:  if (w_last_issue) state_d = S_DRAIN;
            S_DRAIN: if (w_pop && w_head_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (w_issue) begin
            addr_d = (addr_q == C_LAST_ADDR) ? '0 : addr_q + AW'(1);
            iss_d  = iss_q + (AW + 1)'(1);
        end

        infl_d = infl_q;
        if (w_issue && !w_push)      infl_d = infl_q + CW'(1);
        else if (!w_issue && w_push) infl_d = infl_q - CW'(1);

        cnt_d = cnt_q;
        if (w_push && !w_pop)      cnt_d = cnt_q + CW'(1);
        else if (!w_push && w_pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            iss_q   <= '0;
            len_q   <= '0;
            infl_q  <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            pv_q    <= '0;
            pl_q    <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fd_q[k] <= '0;
                fl_q[k] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            iss_q   <= iss_d;
            len_q   <= len_d;
            infl_q  <= infl_d;
            cnt_q   <= cnt_d;
            pv_q[0] <= w_issue;
            pl_q[0] <= w_last_issue;
            for (int k = 1; k < N_DELAY; k++) begin
                pv_q[k] <= pv_q[k-1];
                pl_q[k] <= pl_q[k-1];
            end
            if (w_push) begin
                fd_q[wp_q] <= dob;
                fl_q[wp_q] <= pl_q[N_DELAY-1];
                wp_q       <= (wp_q == C_LAST_PTR) ? '0 : wp_q + PW'(1);
            end
            if (w_pop) begin
                rp_q <= (rp_q == C_LAST_PTR) ? '0 : rp_q + PW'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (cnt_q == C_FULL)));

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign enb     = w_issue;
    assign addrb   = addr_q;
    assign m_valid = (cnt_q != '0);
    assign m_data  = fd_q[rp_q];
    assign m_last  = m_valid && fl_q[rp_q];

endmodule
`default_nettype wire
